// File: rtl/datapath.sv
// datapath: 32-bit Mini-SRC style bus datapath.
// Sixteen GPRs plus PC, IR, MAR, MDR, Y, Zhi:Zlo, HI and LO share one bus.
// A combinational ALU computes Y op bus into Z.
// Optional feature macro: DATAPATH_MULDIV_EN enables the MUL and DIV opcodes.
// When it is not defined, both opcodes yield a zero result.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [15:0]      R_rd,
  input  logic [15:0]      R_wrt,
  input  logic             HI_out,
  input  logic             LO_out,
  input  logic             Zhi_out,
  input  logic             Zlo_out,
  input  logic             PC_out,
  input  logic             MDR_out,
  input  logic             MAR_out,
  input  logic             In_out,
  input  logic             C_out,
  input  logic             MAR_rd,
  input  logic             Zlo_rd,
  input  logic             PC_rd,
  input  logic             MDR_rd,
  input  logic             IR_rd,
  input  logic             Y_rd,
  input  logic             IncPC,
  input  logic             Read,
  input  logic [4:0]       op_sel,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             BAout,
  output logic [WIDTH-1:0] r0_view,
  output logic [WIDTH-1:0] r5_view,
  output logic [WIDTH-1:0] Y_view,
  output logic [WIDTH-1:0] Zlo_view,
  output logic [WIDTH-1:0] MDR_view,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] Data_view,
  output logic [WIDTH-1:0] PC_view
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
    OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
    OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
    OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
    OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  logic [WIDTH-1:0]   r_gpr [16];
  logic [WIDTH-1:0]   r_pc, r_ir, r_mar, r_mdr, r_y, r_zhi, r_zlo, r_hi, r_lo;
  logic [WIDTH-1:0]   w_bus;
  logic [2*WIDTH-1:0] w_res;
  logic [2*WIDTH-1:0] w_rot;
  logic [4:0]         w_shamt;
`ifdef DATAPATH_MULDIV_EN
  logic [WIDTH-1:0]   w_quot, w_rem;
`endif

  assign w_shamt = w_bus[4:0];

  // Bus source select: later assignments override earlier ones, so sources
  // are listed from lowest to highest priority and R0 ends up on top.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    w_bus = '0;
    if (C_out)   w_bus = {{(WIDTH-19){r_ir[18]}}, r_ir[18:0]};
    if (In_out)  w_bus = '0;
    if (MAR_out) w_bus = r_mar;
    if (MDR_out) w_bus = r_mdr;
    if (PC_out)  w_bus = r_pc;
    if (Zlo_out) w_bus = r_zlo;
    if (Zhi_out) w_bus = r_zhi;
    if (LO_out)  w_bus = r_lo;
    if (HI_out)  w_bus = r_hi;
    for (int i = 15; i >= 0; i--) begin
      if (R_wrt[i]) w_bus = (i == 0 && BAout) ? '0 : r_gpr[i];
    end
  end

  // ALU: A = Y, B = bus; 64-bit result, upper half zero unless MUL/DIV.
  always_comb begin
    w_res = '0;
    w_rot = {r_y, r_y};
`ifdef DATAPATH_MULDIV_EN
    w_quot = '0;
    w_rem  = '0;
`endif
    case (op_sel)
      OP_ADD, OP_ADDI: w_res[WIDTH-1:0] = r_y + w_bus;
      OP_SUB:          w_res[WIDTH-1:0] = r_y - w_bus;
      OP_AND, OP_ANDI: w_res[WIDTH-1:0] = r_y & w_bus;
      OP_OR,  OP_ORI:  w_res[WIDTH-1:0] = r_y | w_bus;
      OP_ROR: begin
        w_rot = {r_y, r_y} >> w_shamt;
        w_res[WIDTH-1:0] = w_rot[WIDTH-1:0];
      end
      OP_ROL: begin
        w_rot = {r_y, r_y} << w_shamt;
        w_res[WIDTH-1:0] = w_rot[2*WIDTH-1:WIDTH];
      end
      OP_SHR:  w_res[WIDTH-1:0] = r_y >> w_shamt;
      OP_SHRA: w_res[WIDTH-1:0] = $signed(r_y) >>> w_shamt;
      OP_SHL:  w_res[WIDTH-1:0] = r_y << w_shamt;
`ifdef DATAPATH_MULDIV_EN
      OP_DIV: begin
        if (w_bus == '0) begin
          w_res = {r_y, {WIDTH{1'b1}}};
        end else begin
          w_quot = $signed(r_y) / $signed(w_bus);
          w_rem  = $signed(r_y) % $signed(w_bus);
          w_res  = {w_rem, w_quot};
        end
      end
      OP_MUL: w_res = $signed({{WIDTH{r_y[WIDTH-1]}}, r_y})
                    * $signed({{WIDTH{w_bus[WIDTH-1]}}, w_bus});
`endif
      OP_NEG:  w_res[WIDTH-1:0] = '0 - w_bus;
      OP_NOT:  w_res[WIDTH-1:0] = ~w_bus;
      default: w_res = '0;
    endcase
  end

  // Register file and special registers: synchronous clear, then loads.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; Y loaded this edge cannot feed the ALU result.
    if (clr) begin
      // NOTE: the register file is cleared too; it is flops, not a RAM macro,
      // and every register must read 0 after reset.
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_y   <= '0;
      r_zhi <= '0;
      r_zlo <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (R_rd[i]) r_gpr[i] <= w_bus;
      end
      if (MAR_rd) r_mar <= w_bus;
      if (IR_rd)  r_ir  <= w_bus;
      if (Y_rd)   r_y   <= w_bus;
      if (MDR_rd) r_mdr <= Read ? Mdatain : w_bus;
      if (PC_rd)      r_pc <= w_bus;
      else if (IncPC) r_pc <= r_pc + WIDTH'(1);
      if (Zlo_rd) begin
        r_zhi <= w_res[2*WIDTH-1:WIDTH];
        r_zlo <= w_res[WIDTH-1:0];
        // HI/LO follow MUL/DIV results; with the feature off they load zero.
        if (op_sel == OP_MUL || op_sel == OP_DIV) begin
          r_hi <= w_res[2*WIDTH-1:WIDTH];
          r_lo <= w_res[WIDTH-1:0];
        end
      end
    end
  end

  assign r0_view   = r_gpr[0];
  assign r5_view   = r_gpr[5];
  assign Y_view    = r_y;
  assign Zlo_view  = r_zlo;
  assign MDR_view  = r_mdr;
  assign BusMuxOut = w_bus;
  assign Data_view = r_ir;
  assign PC_view   = r_pc;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed plus randomized bench for datapath with a
// behavioural model of every register and the bus.
module tb_datapath;

  logic        clk;
  logic        clr;
  logic [15:0] R_rd, R_wrt;
  logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
  logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, IncPC, Read, BAout;
  logic [4:0]  op_sel;
  logic [31:0] Mdatain;
  logic [31:0] r0_view, r5_view, Y_view, Zlo_view, MDR_view, BusMuxOut, Data_view, PC_view;

  int errors = 0;
  int checks = 0;

  // Model state.
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo, m_hi, m_lo;

  datapath dut (
    .clk(clk), .clr(clr), .R_rd(R_rd), .R_wrt(R_wrt),
    .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PC_out(PC_out), .MDR_out(MDR_out), .MAR_out(MAR_out), .In_out(In_out),
    .C_out(C_out), .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd),
    .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd), .IncPC(IncPC), .Read(Read),
    .op_sel(op_sel), .Mdatain(Mdatain), .BAout(BAout),
    .r0_view(r0_view), .r5_view(r5_view), .Y_view(Y_view), .Zlo_view(Zlo_view),
    .MDR_view(MDR_view), .BusMuxOut(BusMuxOut), .Data_view(Data_view), .PC_view(PC_view)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    clr = 0; R_rd = 0; R_wrt = 0;
    HI_out = 0; LO_out = 0; Zhi_out = 0; Zlo_out = 0; PC_out = 0;
    MDR_out = 0; MAR_out = 0; In_out = 0; C_out = 0;
    MAR_rd = 0; Zlo_rd = 0; PC_rd = 0; MDR_rd = 0; IR_rd = 0; Y_rd = 0;
    IncPC = 0; Read = 0; BAout = 0; op_sel = 0; Mdatain = 0;
  endtask

  // First active source in priority order supplies the bus.
  function automatic logic [31:0] ref_bus();
    for (int i = 0; i < 16; i++)
      if (R_wrt[i]) return (i == 0 && BAout) ? 32'h0 : m_r[i];
    if (HI_out)  return m_hi;
    if (LO_out)  return m_lo;
    if (Zhi_out) return m_zhi;
    if (Zlo_out) return m_zlo;
    if (PC_out)  return m_pc;
    if (MDR_out) return m_mdr;
    if (MAR_out) return m_mar;
    if (In_out)  return 32'h0;
    if (C_out)   return {{13{m_ir[18]}}, m_ir[18:0]};
    return 32'h0;
  endfunction

  function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
    int unsigned n;
    longint sa, sb, q, r, t;
    logic [31:0] lo;
    n  = b[4:0];
    sa = $signed(a);
    sb = $signed(b);
    lo = a;
    case (op)
      5'd3, 5'd12: return {32'h0, a + b};
      5'd4:        return {32'h0, a - b};
      5'd5, 5'd13: return {32'h0, a & b};
      5'd6, 5'd14: return {32'h0, a | b};
      5'd7: begin repeat (n) lo = {lo[0], lo[31:1]}; return {32'h0, lo}; end
      5'd8: begin repeat (n) lo = {lo[30:0], lo[31]}; return {32'h0, lo}; end
      5'd9:  return {32'h0, a >> n};
      5'd10: begin t = sa >>> n; return {32'h0, t[31:0]}; end
      5'd11: return {32'h0, a << n};
`ifdef DATAPATH_MULDIV_EN
      5'd15: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      5'd16: begin t = sa * sb; return t; end
`endif
      5'd17: return {32'h0, 32'h0 - b};
      5'd18: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  task automatic check_views();
    check("r0_view",   r0_view,   m_r[0]);
    check("r5_view",   r5_view,   m_r[5]);
    check("Y_view",    Y_view,    m_y);
    check("Zlo_view",  Zlo_view,  m_zlo);
    check("MDR_view",  MDR_view,  m_mdr);
    check("Data_view", Data_view, m_ir);
    check("PC_view",   PC_view,   m_pc);
  endtask

  // Check the bus, advance the model by one edge, clock the DUT, check views.
  task automatic tick();
    logic [31:0] bus;
    logic [63:0] res;
    #1;
    bus = ref_bus();
    res = ref_alu(m_y, bus, op_sel);
    check("bus", BusMuxOut, bus);
    if (clr) begin
      for (int i = 0; i < 16; i++) m_r[i] = 0;
      {m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo, m_hi, m_lo} = '0;
    end else begin
      for (int i = 0; i < 16; i++) if (R_rd[i]) m_r[i] = bus;
      if (MAR_rd) m_mar = bus;
      if (IR_rd)  m_ir = bus;
      if (Y_rd)   m_y = bus;
      if (MDR_rd) m_mdr = Read ? Mdatain : bus;
      if (PC_rd) m_pc = bus;
      else if (IncPC) m_pc = m_pc + 1;
      if (Zlo_rd) begin
        {m_zhi, m_zlo} = res;
        if (op_sel == 5'd15 || op_sel == 5'd16) {m_hi, m_lo} = res;
      end
    end
    @(posedge clk);
    #1;
    check_views();
  endtask

  // Load a value into MDR from memory data.
  task automatic mdr_load(input logic [31:0] v);
    clear_ctl(); Mdatain = v; Read = 1; MDR_rd = 1; tick();
  endtask

  initial begin
    logic [63:0] exp_mul, exp_div;
`ifdef DATAPATH_MULDIV_EN
    exp_mul = 64'hFFFF_FFFF_FFFF_FFFE;
    exp_div = 64'h0000_0007_FFFF_FFFF;
`else
    exp_mul = 64'h0;
    exp_div = 64'h0;
`endif
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    {m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo, m_hi, m_lo} = '0;
    clear_ctl();
    @(posedge clk); #1;

    // Reset.
    clr = 1; tick(); clear_ctl();
    check("reset_pc", PC_view, 32'h0);
    check("reset_bus", BusMuxOut, 32'h0);

    // Load R0 = 0x40 via MDR.
    mdr_load(32'h40);
    check("mdr_40", MDR_view, 32'h40);
    clear_ctl(); MDR_out = 1; R_rd = 16'h0001; tick();
    check("r0_40", r0_view, 32'h40);

    // NEG R0 -> Z -> R5.
    clear_ctl(); R_wrt = 16'h0001; op_sel = 5'b10001; Zlo_rd = 1; tick();
    check("neg_zlo", Zlo_view, 32'hFFFF_FFC0);
    clear_ctl(); Zlo_out = 1; R_rd = 16'h0020; tick();
    check("neg_r5", r5_view, 32'hFFFF_FFC0);

    // ADD: R5 = 0x19, Y = R0, Z = Y + R5.
    mdr_load(32'h19);
    clear_ctl(); MDR_out = 1; R_rd = 16'h0020; tick();
    clear_ctl(); R_wrt = 16'h0001; Y_rd = 1; tick();
    clear_ctl(); R_wrt = 16'h0020; op_sel = 5'b00011; Zlo_rd = 1; tick();
    check("add_zlo", Zlo_view, 32'h59);

    // PC load, increment, load-over-increment.
    mdr_load(32'h7);
    clear_ctl(); MDR_out = 1; PC_rd = 1; tick();
    check("pc_load", PC_view, 32'h7);
    clear_ctl(); IncPC = 1; tick();
    check("pc_inc", PC_view, 32'h8);
    mdr_load(32'h3);
    clear_ctl(); MDR_out = 1; PC_rd = 1; IncPC = 1; tick();
    check("pc_prio", PC_view, 32'h3);

    // MUL 0xFFFFFFFF * 2.
    mdr_load(32'hFFFF_FFFF);
    clear_ctl(); MDR_out = 1; Y_rd = 1; tick();
    mdr_load(32'h2);
    clear_ctl(); MDR_out = 1; op_sel = 5'b10000; Zlo_rd = 1; tick();
    check("mul_zlo", Zlo_view, exp_mul[31:0]);
    clear_ctl(); Zhi_out = 1; #1; check("mul_zhi", BusMuxOut, exp_mul[63:32]);
    clear_ctl(); HI_out = 1;  #1; check("mul_hi",  BusMuxOut, exp_mul[63:32]);
    clear_ctl(); LO_out = 1;  #1; check("mul_lo",  BusMuxOut, exp_mul[31:0]);

    // DIV 7 / 0.
    mdr_load(32'h7);
    clear_ctl(); MDR_out = 1; Y_rd = 1; tick();
    mdr_load(32'h0);
    clear_ctl(); MDR_out = 1; op_sel = 5'b01111; Zlo_rd = 1; tick();
    check("div0_zlo", Zlo_view, exp_div[31:0]);
    clear_ctl(); Zhi_out = 1; #1; check("div0_zhi", BusMuxOut, exp_div[63:32]);
    clear_ctl(); HI_out = 1;  #1; check("div0_hi",  BusMuxOut, exp_div[63:32]);

    // Bus priority, BAout, idle bus.
    clear_ctl(); R_wrt = 16'h0001; MDR_out = 1; #1;
    check("prio_r0", BusMuxOut, 32'h40);
    BAout = 1; #1;
    check("prio_baout", BusMuxOut, 32'h0);
    clear_ctl(); #1;
    check("bus_idle", BusMuxOut, 32'h0);

    // Reset overrides active loads.
    clear_ctl(); clr = 1; R_rd = 16'hFFFF; MDR_out = 1; Y_rd = 1; PC_rd = 1;
    IR_rd = 1; Zlo_rd = 1; op_sel = 5'b00011; MDR_rd = 1; Read = 1; Mdatain = 32'h1234;
    tick();
    check("clr_r0", r0_view, 32'h0);
    check("clr_pc", PC_view, 32'h0);
    check("clr_mdr", MDR_view, 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] b;
      clear_ctl();
      case ($urandom_range(0, 3))
        0: R_wrt = 16'(1 << $urandom_range(0, 15));
        1: R_wrt = 16'($urandom) & 16'($urandom);
        default: R_wrt = 0;
      endcase
      R_rd = 16'($urandom) & 16'($urandom);
      {HI_out, LO_out, Zhi_out, Zlo_out} = {($urandom_range(0,9)==0), ($urandom_range(0,9)==0),
                                            ($urandom_range(0,9)==0), ($urandom_range(0,9)==0)};
      {PC_out, MDR_out, MAR_out, In_out, C_out} = {($urandom_range(0,9)==0), ($urandom_range(0,3)==0),
                                                   ($urandom_range(0,9)==0), ($urandom_range(0,9)==0),
                                                   ($urandom_range(0,7)==0)};
      {MAR_rd, Zlo_rd, PC_rd, MDR_rd} = 4'($urandom);
      {IR_rd, Y_rd, IncPC, Read, BAout} = 5'($urandom);
      op_sel  = 5'($urandom_range(0, 31));
      Mdatain = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      clr     = ($urandom_range(0, 63) == 0);
      #1;
      b = ref_bus();
      if (op_sel == 5'd15 && m_y == 32'h8000_0000 && b == 32'hFFFF_FFFF) op_sel = 5'd3;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit bus-based CPU datapath (Mini-SRC style) used in the ELEC374 processor.
- Sixteen general registers R0–R15, plus PC, IR, MAR, MDR, Y, 64-bit Z (Zhi:Zlo), HI and LO.
- All of these share one 32-bit bus driven by an encoder/multiplexer.
- A combinational ALU computes Y op Bus into Z. The control unit, or a bench, drives every strobe directly.

Parameters:
- WIDTH, 32, datapath/bus width. Fixed at 32; the opcode table assumes 32.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- clr  in  1  synchronous, active-high reset.
- R_rd  in  16  bit i: Ri loads from the bus.
- R_wrt  in  16  bit i: Ri drives the bus.
- HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out  in  1 each  bus-source selects.
- MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd  in  1 each  register load enables.
- IncPC  in  1  PC <= PC+1.
- Read  in  1  MDR input mux: 1 = Mdatain, 0 = bus.
- op_sel  in  5  ALU opcode.
- Mdatain  in  32  memory read data.
- BAout  in  1  base-address mode: R0 drives 0 when selected.
- r0_view, r5_view  out  32  R0 and R5 contents.
- Y_view  out  32  Y contents.
- Zlo_view  out  32  Zlo contents.
- MDR_view  out  32  MDR contents.
- BusMuxOut  out  32  current bus value.
- Data_view  out  32  IR contents.
- PC_view  out  32  PC contents.

Behaviour:
- Reset: when clr=1 at a rising edge, every register (R0–R15, PC, IR, MAR, MDR, Y, Zhi, Zlo, HI, LO) becomes 0. Reset overrides all load enables. All view outputs read 0 on the following cycle.
- Bus (combinational), fixed priority, first match wins:
  - R_wrt[0]..R_wrt[15], lowest index first. R0 drives 0 if BAout=1.
  - Then HI, LO, Zhi, Zlo, PC, MDR, MAR, In, C.
  - In_out drives 32'h0; there is no input port in this block.
  - C_out drives IR[18:0] sign-extended.
  - No select active: bus = 0.
- Register loads at the rising edge:
  - Any enabled destination captures the bus. Several destinations may load in the same cycle.
  - MDR_rd loads Mdatain if Read=1, else the bus.
- PC:
  - PC_rd=1 loads the bus. This has priority over IncPC.
  - Otherwise IncPC=1 increments PC by 1, wrapping 0xFFFFFFFF to 0.
- ALU (combinational): A = Y, B = bus. Result is 64 bits; Zhi=0 unless stated. Opcodes:
  - 00011 ADD; 00100 SUB (A−B); 00101 AND; 00110 OR.
  - 00111 ROR A by B[4:0]; 01000 ROL.
  - 01001 SHR (logical); 01010 SHRA (arithmetic); 01011 SHL.
  - 01100 ADDI = ADD; 01101 ANDI = AND; 01110 ORI = OR.
  - 01111 DIV, signed: Zlo = quotient, Zhi = remainder. B=0 gives Zlo = 0xFFFFFFFF, Zhi = A.
  - 10000 MUL, signed 64-bit product in Zhi:Zlo.
  - 10001 NEG: Zlo = −B (unary, Y ignored).
  - 10010 NOT: Zlo = ~B.
  - Any other code: result 0. Arithmetic wraps modulo 2^32, with no flags.
- Z: Zlo_rd=1 loads both Zhi and Zlo from the ALU result. The Y loaded at the same edge does not affect the result; ALU inputs are pre-edge values.
- HI/LO: on a Zlo_rd edge with op_sel MUL or DIV, HI <= result[63:32] and LO <= result[31:0]. Otherwise they hold.
- MAR: loads from the bus on MAR_rd. It is also readable onto the bus via MAR_out.

Optional Feature:
- DATAPATH_MULDIV_EN.
- Defined: MUL and DIV are implemented as above and update HI/LO.
- Undefined: opcodes 01111 and 10000 yield a 0 result. HI and LO still load 0 under the same rule, which keeps area small.

Test Plan:
- Load R0: Mdatain=0x40 with Read=1 and MDR_rd=1 for one edge. Next cycle MDR_out=1 and R_rd[0]=1 -> r0_view=0x00000040, MDR_view=0x40.
- NEG: R0=0x40; R_wrt[0]=1, op_sel=10001, Zlo_rd=1 for one edge. Then Zlo_out=1 and R_rd[5]=1 -> Zlo_view=0xFFFFFFC0, r5_view=0xFFFFFFC0.
- ADD: R0=0x40, R5=0x19; Y_rd with R0 on the bus. Then R_wrt[5]=1, op_sel=00011, Zlo_rd=1 -> Zlo_view=0x59.
- PC: MDR=7; MDR_out=1 and PC_rd=1 -> PC_view=7. IncPC=1 alone -> 8. PC_rd and IncPC together with bus=3 -> 3.
- MUL: Y=0xFFFFFFFF, bus=2, op 10000 -> Zhi=0xFFFFFFFF, Zlo=0xFFFFFFFE, HI/LO equal to these. DIV 7/0 -> Zlo=0xFFFFFFFF, Zhi=7.
- Bus priority and reset: R_wrt[0] and MDR_out both asserted -> bus = R0. With BAout=1 -> bus=0. No select -> bus=0. Assert clr mid-sequence with loads active -> all views 0 next cycle.
